uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
// - Receive side of the UART link: oversampled serial receiver.
// - Recovers start / data / optional parity / stop framing from rx_in.
// - Presents the parallel word with a one-cycle data_valid strobe.
// - Checks parity and stop bit; frame settings (par_en, par_typ, data_width) match the UART_TX block.
// - Sits between the pad-side synchroniser and the RX FIFO / consumer logic.
// PARAMETERS
// - data_width  8  data bits per frame, LSB first
// - PRESC_W     6  width of the prescale input
// PORTS
// - clk        in   1           oversampling clock; prescale cycles per bit
// - rst        in   1           asynchronous, active-low reset
// - rx_in      in   1           serial line, already synchronised to clk; idles high
// - prescale   in   PRESC_W     cycles per bit; legal values 8, 16, 32
// - par_en     in   1           1 = a parity bit follows the data
// - par_typ    in   1           0 = even parity, 1 = odd parity
// - p_data     out  data_width  last good received word
// - data_valid out  1           one-cycle strobe: p_data has been updated
// - par_err    out  1           one-cycle strobe: parity mismatch
// - stp_err    out  1           one-cycle strobe: stop bit sampled 0
// BEHAVIOUR
// - Reset (async assert, sync release): FSM=IDLE, all counters 0.
//   - All outputs 0, including p_data.
//   - Reset mid-frame abandons the frame silently: no strobes, p_data=0.
// - Frame settings: prescale, par_en and par_typ are latched on the IDLE->START transition.
//   - Changes during a frame have no effect on that frame.
// - FSM states: IDLE -> START -> DATA -> (PARITY if par_en) -> STOP -> IDLE.
// - Timing reference: cycle 0 is the first cycle rx_in is sampled 0 in IDLE.
//   - Bit k occupies cycles k*prescale .. k*prescale+prescale-1.
//   - Counters: edge_cnt runs 0..prescale-1 and wraps; bit_cnt runs 0..data_width-1.
// - Sample point: the cycle k*prescale + prescale/2.
// - IDLE: stays while rx_in=1.
// - START: a start sample of 1 is a glitch.
//   - FSM returns to IDLE at the end of that cycle; no strobes.
// - DATA: sample shifted into a shift register, LSB first.
//   - Leaves after bit_cnt = data_width-1 at edge_cnt = prescale-1.
// - PARITY: expected bit = ^data for even parity, ~^data for odd parity.
//   - A mismatch is held as a pending error.
// - STOP: a sample of 0 is held as a pending stop error.
//   - At edge_cnt = prescale-1 the FSM returns to IDLE.
// - Strobes: with N = 2 + data_width + par_en, all strobes are registered and appear in cycle N*prescale only.
//   - No errors: data_valid=1 and p_data <= shift register.
//   - Any error: the matching par_err and/or stp_err = 1; data_valid=0; p_data holds its old value.
// - Back-to-back frames: a start bit immediately after the stop bit is detected in IDLE.
//   - The strobe cycle and the new frame's cycle 0 may coincide. Both must be handled; no frame is lost.
// - Line held low after a stop error: treated as a new start bit and received as a normal frame.
// CONFIGURATION
// - UART_RX_MAJORITY_EN defined:
//   - Each bit is sampled at offsets prescale/2-1, prescale/2 and prescale/2+1.
//   - The bit value is the 2-of-3 majority, decided at offset prescale/2+1.
//   - Strobe cycle is unchanged.
// - UART_RX_MAJORITY_EN undefined: single sample at offset prescale/2; no extra sample registers.
// TESTING
// - T1: prescale=8, par_en=0, frame 0xA5, stop=1.
//   - Expect data_valid=1 in cycle 80 only; p_data=0xA5; par_err=0; stp_err=0.
// - T2: prescale=16, par_en=1, par_typ=0, data 0x3C with parity bit 0.
//   - Expect data_valid in cycle 176; p_data=0x3C.
//   - Same frame with parity bit 1: expect par_err pulse in cycle 176, data_valid=0, p_data stays 0x3C.
// - T3: prescale=8, par_en=1, par_typ=1, data 0x01 with parity 0, stop bit 0.
//   - Expect stp_err=1 in cycle 88 only; data_valid=0.
// - T4: prescale=16, rx_in low for 3 cycles, then high.
//   - Expect FSM back in IDLE by cycle 9; no strobes.
//   - A following valid 0x81 frame is received correctly.
// - T5: prescale=32, frames 0x55 then 0xFF back-to-back, no idle gap.
//   - Expect two data_valid pulses 320 cycles apart, with p_data 0x55 then 0xFF.
// - T6: rst asserted in the DATA state of an 0xAA frame.
//   - Expect all outputs 0 immediately; no strobe.
//   - Next frame 0x0F is received with p_data=0x0F.
//   - With UART_RX_MAJORITY_EN: additionally, a one-cycle inverted pulse on each bit's centre sample
//     of frame 0xC3 must still yield p_data=0xC3.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampled UART receiver with start/data/parity/stop framing,
//               parity and stop checking, and one-cycle result strobes.
//               Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int c_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PRESC_W-1:0]    r_edge_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [PRESC_W-1:0]    r_presc;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_pend_par;
    logic                  r_pend_stp;

    logic [PRESC_W-1:0]    w_half;
    logic                  w_last_edge;
    logic                  w_last_bit;
    logic                  w_sample_tick;
    logic                  w_bit;
    logic                  w_exp_par;

    assign w_half      = r_presc >> 1;
    assign w_last_edge = (r_edge_cnt == (r_presc - PRESC_W'(1)));
    assign w_last_bit  = (r_bit_cnt == c_BIT_W'(DATA_WIDTH - 1));
    assign w_exp_par   = r_par_typ ? ~(^r_shift) : (^r_shift);

`ifdef UART_RX_MAJORITY_EN
    logic r_early;
    logic r_centre;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_early  <= 1'b0;
            r_centre <= 1'b0;
        end else begin
            if (r_edge_cnt == (w_half - PRESC_W'(1))) r_early  <= rx_in;
            if (r_edge_cnt == w_half)                 r_centre <= rx_in;
        end
    end

    // The decision lands on the third sample, using the live line for it.
    assign w_sample_tick = (r_edge_cnt == (w_half + PRESC_W'(1)));
    assign w_bit         = (r_early & r_centre) | (r_early & rx_in) | (r_centre & rx_in);
`else
    assign w_sample_tick = (r_edge_cnt == w_half);
    assign w_bit         = rx_in;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!rx_in) w_next = S_START;
            S_START: begin
                if (w_sample_tick && w_bit) w_next = S_IDLE;
                else if (w_last_edge)       w_next = S_DATA;
            end
            S_DATA:   if (w_last_edge && w_last_bit) w_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_last_edge) w_next = S_STOP;
            S_STOP:   if (w_last_edge) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_presc    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_shift    <= '0;
            r_pend_par <= 1'b0;
            r_pend_stp <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
                if (!rx_in) begin
                    // The detecting cycle is bit offset 0, so the count resumes at 1.
                    r_edge_cnt <= PRESC_W'(1);
                    r_presc    <= prescale;
                    r_par_en   <= par_en;
                    r_par_typ  <= par_typ;
                    r_pend_par <= 1'b0;
                    r_pend_stp <= 1'b0;
                end else begin
                    r_edge_cnt <= '0;
                end
            end else begin
                r_edge_cnt <= w_last_edge ? '0 : r_edge_cnt + PRESC_W'(1);
                if (r_state == S_DATA && w_last_edge)
                    r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + c_BIT_W'(1);
                if (w_sample_tick) begin
                    case (r_state)
                        S_DATA:   r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                        S_PARITY: r_pend_par <= (w_bit != w_exp_par);
                        S_STOP:   r_pend_stp <= ~w_bit;
                        default:  ;
                    endcase
                end
                if (r_state == S_STOP && w_last_edge) begin
                    if (!r_pend_par && !r_pend_stp) begin
                        data_valid <= 1'b1;
                        p_data     <= r_shift;
                    end
                    par_err <= r_pend_par;
                    stp_err <= r_pend_stp;
                end
            end
        end
    end

endmodule
`default_nettype wire
